// File: rtl/change_dispenser_pkg.sv
// Shared encodings for the change dispenser: main-FSM states, coin types,
// dispenser states and the default coin denominations.
package change_dispenser_pkg;

    localparam logic [2:0] MS_REFUND = 3'd2;
    localparam logic [2:0] MS_CHANGE = 3'd3;

    localparam logic [1:0] COIN_TYPE_A = 2'd0;
    localparam logic [1:0] COIN_TYPE_B = 2'd1;
    localparam logic [1:0] COIN_TYPE_C = 2'd2;
    localparam logic [1:0] COIN_TYPE_D = 2'd3;

    localparam int DEF_COIN_A = 10;
    localparam int DEF_COIN_B = 5;
    localparam int DEF_COIN_C = 2;
    localparam int DEF_COIN_D = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_DONE     = 2'd2,
        ST_HOLD     = 2'd3
    } disp_state_t;

endpackage

// File: rtl/change_dispenser_coin_selector.sv
// Greedy largest-coin-first selection for the amount still owed.
module change_dispenser_coin_selector
    import change_dispenser_pkg::*;
#(
    parameter int COIN_A = DEF_COIN_A,
    parameter int COIN_B = DEF_COIN_B,
    parameter int COIN_C = DEF_COIN_C,
    parameter int COIN_D = DEF_COIN_D
) (
    input  logic [4:0] remaining,
    output logic [1:0] coinType,
    output logic [4:0] coinValue
);

    always_comb begin
        coinType  = COIN_TYPE_D;
        coinValue = 5'(COIN_D);
        if (remaining >= 5'(COIN_A)) begin
            coinType  = COIN_TYPE_A;
            coinValue = 5'(COIN_A);
        end else if (remaining >= 5'(COIN_B)) begin
            coinType  = COIN_TYPE_B;
            coinValue = 5'(COIN_B);
        end else if (remaining >= 5'(COIN_C)) begin
            coinType  = COIN_TYPE_C;
            coinValue = 5'(COIN_C);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change/refund amount out as a stream of coins over a valid/ready
// handshake, once per transaction, re-arming only after the main FSM moves on.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int COIN_A = DEF_COIN_A,
    parameter int COIN_B = DEF_COIN_B,
    parameter int COIN_C = DEF_COIN_C,
    parameter int COIN_D = DEF_COIN_D
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] mainState,
    input  logic [4:0] moneyToGive,
    input  logic       coinReady,
    output logic       coinValid,
    output logic [1:0] coinType,
    output logic       busy,
    output logic       done,
    output logic [4:0] coinCount
);

    disp_state_t state_q, state_d;
    logic [4:0]  remaining_q, remaining_d;
    logic [4:0]  count_q, count_d;
    logic [1:0]  sel_type;
    logic [4:0]  sel_value;
    logic        in_pay;

    change_dispenser_coin_selector #(
        .COIN_A(COIN_A),
        .COIN_B(COIN_B),
        .COIN_C(COIN_C),
        .COIN_D(COIN_D)
    ) u_sel (
        .remaining(remaining_q),
        .coinType (sel_type),
        .coinValue(sel_value)
    );

    assign in_pay = (mainState == MS_REFUND) || (mainState == MS_CHANGE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= 5'd0;
            count_q     <= 5'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_pay && (moneyToGive != 5'd0)) begin
                    remaining_d = moneyToGive;
                    count_d     = 5'd0;
                    state_d     = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                if (coinReady) begin
                    // COIN_D == 1 guarantees sel_value <= remaining_q here
                    remaining_d = remaining_q - sel_value;
                    count_d     = count_q + 5'd1;
                    if (remaining_d == 5'd0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!in_pay) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign coinValid = (state_q == ST_DISPENSE);
    assign coinType  = (state_q == ST_DISPENSE) ? sel_type : COIN_TYPE_A;
    assign busy      = (state_q == ST_DISPENSE) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign coinCount = count_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a greedy
// coin-list reference model.
module tb_change_dispenser;

    logic       clock;
    logic       reset;
    logic [2:0] mainState;
    logic [4:0] moneyToGive;
    logic       coinReady;
    logic       coinValid;
    logic [1:0] coinType;
    logic       busy;
    logic       done;
    logic [4:0] coinCount;

    int n_checks;
    int n_fail;
    int denom[4];

    change_dispenser dut (
        .clock      (clock),
        .reset      (reset),
        .mainState  (mainState),
        .moneyToGive(moneyToGive),
        .coinReady  (coinReady),
        .coinValid  (coinValid),
        .coinType   (coinType),
        .busy       (busy),
        .done       (done),
        .coinCount  (coinCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: greedy coin list computed with plain arithmetic.
    task automatic model_coins(input int amt, output int q[$]);
        int rem;
        q = {};
        rem = amt;
        while (rem > 0) begin
            for (int k = 0; k < 4; k++) begin
                if (denom[k] <= rem) begin
                    q.push_back(k);
                    rem -= denom[k];
                    break;
                end
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clock);
        mainState = 3'd0;
        coinReady = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // mode 0: ready always high, 1: toggling starting low, 2: random
    task automatic run_txn(input logic [2:0] ms, input logic [4:0] amt, input int mode);
        int q[$];
        int n;
        int cycles;
        bit tog;
        model_coins(int'(amt), q);
        n = q.size();
        @(negedge clock);
        mainState   = ms;
        moneyToGive = amt;
        coinReady   = 1'b0;
        @(posedge clock);
        #1 moneyToGive = 5'($urandom_range(31));
        cycles = 0;
        tog = 1'b0;
        while (q.size() > 0 && cycles < 200) begin
            @(negedge clock);
            cycles++;
            case (mode)
                0:       coinReady = 1'b1;
                1:       begin coinReady = tog; tog = !tog; end
                default: coinReady = 1'($urandom_range(1));
            endcase
            check_eq("valid", int'(coinValid), 1);
            check_eq("busy", int'(busy), 1);
            check_eq("done_early", int'(done), 0);
            if (coinReady) begin
                check_eq("type", int'(coinType), q.pop_front());
            end else begin
                check_eq("stall_type", int'(coinType), q[0]);
            end
        end
        check_eq("timeout_left", q.size(), 0);
        if (mode == 0) check_eq("cycles", cycles, n);
        @(negedge clock);
        coinReady = 1'($urandom_range(1));
        check_eq("done_pulse", int'(done), 1);
        check_eq("done_valid", int'(coinValid), 0);
        check_eq("done_busy", int'(busy), 1);
        check_eq("count", int'(coinCount), n);
        @(negedge clock);
        check_eq("hold_done", int'(done), 0);
        check_eq("hold_busy", int'(busy), 0);
        check_eq("hold_valid", int'(coinValid), 0);
        check_eq("hold_count", int'(coinCount), n);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        denom[0] = 10; denom[1] = 5; denom[2] = 2; denom[3] = 1;
        reset       = 1'b0;
        mainState   = 3'd0;
        moneyToGive = 5'd0;
        coinReady   = 1'b0;
        #1;
        check_eq("rst_valid", int'(coinValid), 0);
        check_eq("rst_type", int'(coinType), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_count", int'(coinCount), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        go_idle();

        run_txn(3'd3, 5'd23, 0);
        go_idle();
        run_txn(3'd2, 5'd31, 0);
        go_idle();
        run_txn(3'd3, 5'd9, 1);
        go_idle();

        // zero amount never triggers
        mainState   = 3'd3;
        moneyToGive = 5'd0;
        repeat (10) begin
            @(negedge clock);
            check_eq("zero_idle", int'({coinValid, busy, done}), 0);
        end
        go_idle();

        // no re-trigger while main FSM stays in pay-out
        run_txn(3'd3, 5'd23, 0);
        moneyToGive = 5'd7;
        repeat (10) begin
            @(negedge clock);
            check_eq("hold_notrig", int'({coinValid, busy, done}), 0);
        end
        go_idle();
        run_txn(3'd3, 5'd7, 0);
        go_idle();

        // asynchronous reset during the second coin of 23
        mainState   = 3'd3;
        moneyToGive = 5'd23;
        coinReady   = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #3;
        check_eq("mid_valid_pre", int'(coinValid), 1);
        reset = 1'b0;
        #1;
        check_eq("arst_valid", int'(coinValid), 0);
        check_eq("arst_type", int'(coinType), 0);
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_done", int'(done), 0);
        check_eq("arst_count", int'(coinCount), 0);
        @(negedge clock);
        mainState = 3'd0;
        @(negedge clock);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check_eq("post_rst_idle", int'({coinValid, busy, done}), 0);
        end

        // randomized transactions
        for (int t = 0; t < 25; t++) begin
            go_idle();
            run_txn(($urandom_range(1) != 0) ? 3'd2 : 3'd3,
                    5'($urandom_range(31, 1)), int'($urandom_range(2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
